fp_mult_round_pack: RTL and testbench
=====================================

Name: fp_mult_round_pack

Overview:
- Downstream consumer of the multiplier's 24-bit mantissa right-shifter.
- Takes the shifted mantissa, the guard and sticky bits, the adjusted biased exponent, the sign and the special-case flags.
- Applies IEEE754 round-to-nearest-even, then renormalises any rounding carry.
- Detects overflow/underflow and packs the single-precision result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- MANT_W, 24, mantissa width including hidden bit (fixed for single precision).
- EXP_W, 10, width of the unsigned adjusted exponent input.
- EXP_MAX, 254, largest finite biased exponent.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  stage can accept an operand this cycle.
- in_sign  input  1  result sign.
- in_exp  input  EXP_W  biased exponent, range 0..511. 0 means subnormal (mantissa already right-shifted upstream).
- in_mant  input  MANT_W  shifter output. in_mant[23]=1 whenever in_exp>=1.
- in_guard  input  1  first bit below the mantissa LSB.
- in_sticky  input  1  OR of all bits below guard.
- in_nan, in_inf, in_zero  input  1 each  special-case flags from the classify stage.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  packed IEEE754 single.
- out_overflow, out_underflow, out_inexact  output  1 each  exception flags, aligned with out_result.

Behaviour:
- Reset: all valid bits clear; out_result and all flags 0. in_ready is 1 once reset deasserts. Reset mid-stream discards in-flight data; no output is produced for it.
- Handshake:
  - Transfer occurs when valid and ready are both high on a rising edge.
  - out_valid, once high, holds until accepted. out_result and the flags stay stable while out_valid=1 and out_ready=0.
- Pipeline:
  - S1 register: latches inputs and computes round_up = in_guard & (in_sticky | in_mant[0]), plus the 25-bit sum in_mant + round_up.
  - S2 register: drives the outputs.
  - s2 loads when s1 is valid and (s2 is empty or out_ready=1).
  - s1 loads on an input transfer.
  - in_ready = !s1_valid | s1_advances (combinational, no dependency on in_valid).
  - Latency: accepted at edge N gives out_valid at edge N+2. Throughput is 1 per cycle with out_ready held high.
- Arithmetic (S1 to S2):
  - inexact = guard | sticky.
  - Sum bit 24 set (carry): mant_final = sum[24:1], exp_final = exp+1.
  - Else, exp==0 and sum[23]=1: subnormal rounded up to the minimum normal, exp_final = 1.
  - Else exp_final = exp.
  - exp_final > EXP_MAX: result = {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - exp_final==0: result = {sign, 8'h00, mant_final[22:0]}, underflow = inexact (tininess detected after rounding).
  - Otherwise: result = {sign, exp_final[7:0], mant_final[22:0]}.
- Specials, priority nan > inf > zero; these bypass rounding and all flags are 0:
  - nan: 32'h7FC00000.
  - inf: {sign, 8'hFF, 23'b0}.
  - zero: {sign, 31'b0}.
- Boundaries:
  - Stalled pipeline holds exactly two operands; in_ready=0 until out_ready=1.
  - Simultaneous output accept and input accept while full: no bubble, no loss, order preserved.
  - in_mant = 0xFFFFFF with round_up: carry path, mantissa becomes 0x800000.

Decomposition:
- Shared package fp_pkg holds the constants: EXP_BIAS=127, EXP_MAX=254, QNAN=32'h7FC00000, EXP_INF=8'hFF, field widths.
- One natural sub-module: fp_round_rne, the combinational guard/sticky/LSB increment decision plus the 25-bit add. It is instantiated in S1.
- Packing and flag logic stay in the top.

Test Plan:
- exp=127, mant=0x800000, g=0, s=0, out_ready=1 -> 0x3F800000 on edge N+2, all flags 0.
- exp=127, mant=0x800000, g=1, s=0 (tie, even LSB) -> 0x3F800000, inexact=1.
- exp=127, mant=0xFFFFFF, g=1, s=0 (tie, odd LSB, carry) -> 0x40000000, inexact=1.
- exp=254, mant=0xFFFFFF, g=1, s=1 -> 0x7F800000, overflow=1, inexact=1.
- Subnormal inputs:
  - exp=0, mant=0x7FFFFF, g=1, s=1 -> 0x00800000, underflow=0.
  - exp=0, mant=0x000001, g=0, s=1 -> 0x00000001, underflow=1, inexact=1.
- Three back-to-back operands with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts.
  - out_result stays stable while stalled.
  - On out_ready=1, all three emerge in order.
- nan=1 with inf=1 -> 0x7FC00000, flags 0.
- rst_n pulsed low mid-stream -> out_valid=0 asynchronously; the in-flight operand is never emitted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants, the S1 payload layout and a field packing helper
// for the multiplier round/pack stage.
package fp_pkg;

  localparam int MANT_W   = 24;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = 10;
  localparam int EXPF_W   = 8;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 254;

  localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
  localparam logic [EXPF_W-1:0] EXP_INF = 8'hFF;

  // Operand state carried from S1 into S2: the rounded sum replaces mantissa/guard/sticky.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   sum;
    logic              inexact;
    logic              nan;
    logic              inf;
    logic              zero;
  } s1_payload_t;

  function automatic logic [31:0] pack_word(input logic              sign,
                                            input logic [EXPF_W-1:0] exp,
                                            input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_mult_round_pack_if.sv
// Operand and result handshake bundle between the multiplier shifter, the round/pack
// stage (slave) and whatever drives/consumes it (master).
interface fp_mult_round_pack_if;

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sign;
  logic [fp_pkg::EXP_W-1:0]  in_exp;
  logic [fp_pkg::MANT_W-1:0] in_mant;
  logic                      in_guard;
  logic                      in_sticky;
  logic                      in_nan;
  logic                      in_inf;
  logic                      in_zero;

  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_result;
  logic                      out_overflow;
  logic                      out_underflow;
  logic                      out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky,
           in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky,
           in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment decision and the widened mantissa add that may carry
// one bit past the hidden bit.
module fp_round_rne #(
  parameter int MANT_W = fp_pkg::MANT_W
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [MANT_W:0]   sum_o
);

  logic round_up_s;

  // Ties go up only when the kept LSB is odd.
  always_comb begin
    round_up_s = guard_i & (sticky_i | mant_i[0]);
    sum_o      = {1'b0, mant_i} + {{MANT_W{1'b0}}, round_up_s};
  end

endmodule

// File: rtl/fp_mult_round_pack.sv
// Two-stage round/pack of the multiplier result: S1 latches the operand and the rounded
// sum, S2 renormalises, resolves specials/overflow/underflow and holds the packed word.
module fp_mult_round_pack #(
  parameter int MANT_W  = fp_pkg::MANT_W,
  parameter int EXP_W   = fp_pkg::EXP_W,
  parameter int EXP_MAX = fp_pkg::EXP_MAX
) (
  input logic                  clk,
  input logic                  rst_n,
  fp_mult_round_pack_if.slave  bus
);

  import fp_pkg::QNAN;
  import fp_pkg::EXP_INF;
  import fp_pkg::FRAC_W;
  import fp_pkg::s1_payload_t;
  import fp_pkg::pack_word;

  localparam logic [EXP_W:0] EXP_MAX_X = (EXP_W+1)'(EXP_MAX);
  localparam logic [EXP_W:0] EXP_ONE_X = (EXP_W+1)'(1);

  logic              in_ready_s;
  logic              in_fire_s;
  logic              s1_adv_s;
  logic [MANT_W:0]   sum_s;

  logic              s1_valid_d, s1_valid_q;
  s1_payload_t       s1_d, s1_q;

  logic [EXP_W:0]    exp_fin_s;
  logic [FRAC_W-1:0] frac_fin_s;
  logic [31:0]       res_s;
  logic              ovf_s, unf_s, inx_s;

  logic              s2_valid_d, s2_valid_q;
  logic [31:0]       result_d, result_q;
  logic              ovf_d, ovf_q;
  logic              unf_d, unf_q;
  logic              inx_d, inx_q;

  fp_round_rne #(.MANT_W(MANT_W)) u_round (
    .mant_i   (bus.in_mant),
    .guard_i  (bus.in_guard),
    .sticky_i (bus.in_sticky),
    .sum_o    (sum_s)
  );

  assign s1_adv_s   = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign in_ready_s = ~s1_valid_q | s1_adv_s;
  assign in_fire_s  = bus.in_valid & in_ready_s;

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = s2_valid_q;
  assign bus.out_result    = result_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;
  assign bus.out_inexact   = inx_q;

  // S1 next state: capture a new operand on transfer, otherwise drain or hold.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_fire_s) begin
      s1_valid_d   = 1'b1;
      s1_d.sign    = bus.in_sign;
      s1_d.exp     = bus.in_exp;
      s1_d.sum     = sum_s;
      s1_d.inexact = bus.in_guard | bus.in_sticky;
      s1_d.nan     = bus.in_nan;
      s1_d.inf     = bus.in_inf;
      s1_d.zero    = bus.in_zero;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Renormalise a rounding carry; a subnormal that rounds into bit 23 becomes the minimum normal.
  always_comb begin
    exp_fin_s  = {1'b0, s1_q.exp};
    frac_fin_s = s1_q.sum[FRAC_W-1:0];
    if (s1_q.sum[MANT_W]) begin
      exp_fin_s  = {1'b0, s1_q.exp} + EXP_ONE_X;
      frac_fin_s = s1_q.sum[FRAC_W:1];
    end else if ((s1_q.exp == {EXP_W{1'b0}}) && s1_q.sum[MANT_W-1]) begin
      exp_fin_s = EXP_ONE_X;
    end else begin
      exp_fin_s = {1'b0, s1_q.exp};
    end
  end

  // Pack and flags; specials win over everything and carry no exception flags.
  always_comb begin
    res_s = pack_word(s1_q.sign, exp_fin_s[7:0], frac_fin_s);
    ovf_s = 1'b0;
    unf_s = 1'b0;
    inx_s = s1_q.inexact;
    if (s1_q.nan) begin
      res_s = QNAN;
      inx_s = 1'b0;
    end else if (s1_q.inf) begin
      res_s = pack_word(s1_q.sign, EXP_INF, {FRAC_W{1'b0}});
      inx_s = 1'b0;
    end else if (s1_q.zero) begin
      res_s = {s1_q.sign, 31'h0000_0000};
      inx_s = 1'b0;
    end else if (exp_fin_s > EXP_MAX_X) begin
      res_s = pack_word(s1_q.sign, EXP_INF, {FRAC_W{1'b0}});
      ovf_s = 1'b1;
      inx_s = 1'b1;
    end else if (exp_fin_s == {(EXP_W+1){1'b0}}) begin
      unf_s = s1_q.inexact;
    end else begin
      unf_s = 1'b0;
    end
  end

  // S2 next state: load behind S1, drop on accept, otherwise hold the result stable.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inx_d      = inx_q;
    if (s1_adv_s) begin
      s2_valid_d = 1'b1;
      result_d   = res_s;
      ovf_d      = ovf_s;
      unf_d      = unf_s;
      inx_d      = inx_s;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // S2 register, drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= 32'h0000_0000;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inx_q      <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Directed bench for fp_mult_round_pack: value-level rounding model, scoreboard monitor,
// stall/backpressure, latency and mid-stream reset scenarios.
module tb_fp_mult_round_pack;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic        nan;
    logic        inf;
    logic        zero;
  } op_t;

  // {overflow, underflow, inexact, result}
  typedef logic [34:0] res_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  op_t  drv;

  int   n_cmp;
  int   n_bad;
  int   n_out;
  res_t sb[$];
  logic held_v;
  res_t held;

  fp_mult_round_pack_if bus_if ();

  assign bus_if.in_valid  = in_valid;
  assign bus_if.out_ready = out_ready;
  assign bus_if.in_sign   = drv.sign;
  assign bus_if.in_exp    = drv.exp;
  assign bus_if.in_mant   = drv.mant;
  assign bus_if.in_guard  = drv.guard;
  assign bus_if.in_sticky = drv.sticky;
  assign bus_if.in_nan    = drv.nan;
  assign bus_if.in_inf    = drv.inf;
  assign bus_if.in_zero   = drv.zero;

  fp_mult_round_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t got_now();
    return {bus_if.out_overflow, bus_if.out_underflow, bus_if.out_inexact, bus_if.out_result};
  endfunction

  // Value model: the 31-bit {exponent,fraction} body is one integer, so adding the
  // rounding increment lets a fraction carry ripple into the exponent on its own.
  function automatic res_t model(input op_t o);
    int unsigned below;
    bit          up;
    bit          inexact;
    longint      body;
    longint      e;
    logic [63:0] b;
    if (o.nan)  return {3'b000, 32'h7FC0_0000};
    if (o.inf)  return {3'b000, o.sign, 8'hFF, 23'h0};
    if (o.zero) return {3'b000, o.sign, 31'h0};
    below   = (o.guard ? 2 : 0) + (o.sticky ? 1 : 0);
    up      = (below > 2) || (below == 2 && o.mant[0]);
    inexact = (below != 0);
    body    = (longint'(o.exp) * 64'd8388608) + longint'(o.mant[22:0]) + (up ? 64'd1 : 64'd0);
    e       = body / 64'd8388608;
    if (e > 254) return {3'b101, o.sign, 8'hFF, 23'h0};
    b = 64'(body);
    return {1'b0, (e == 0) && inexact, inexact, o.sign, b[30:0]};
  endfunction

  task automatic chk(input string nm, input res_t act, input res_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %09h expected %09h", nm, act, exp);
    end
  endtask

  // Monitor: inputs only move #1 after posedge, so the negedge sees what the next edge transfers.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      sb.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        n_cmp++;
        if (!(bus_if.out_valid === 1'b1 && got_now() === held)) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b %09h expected v=1 %09h", bus_if.out_valid, got_now(), held);
        end
      end
      if (in_valid && bus_if.in_ready) sb.push_back(model(drv));
      if (bus_if.out_valid && out_ready) begin
        n_cmp++;
        n_out++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got %09h expected no output", got_now());
        end else begin
          e = sb.pop_front();
          if (got_now() !== e) begin
            n_bad++;
            $display("FAIL scoreboard: got %09h expected %09h", got_now(), e);
          end
        end
      end
      held_v = bus_if.out_valid && !out_ready;
      held   = got_now();
    end
  end

  task automatic send(input op_t o);
    bit acc;
    drv      = o;
    in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      acc = bus_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 35'd0, 35'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", 35'(sb.size()), 35'd0);
  endtask

  function automatic op_t mk(input bit s, input int e, input int m, input bit g, input bit st);
    op_t o;
    o = '0;
    o.sign = s; o.exp = 10'(e); o.mant = 24'(m); o.guard = g; o.sticky = st;
    return o;
  endfunction

  op_t  vec[14];
  res_t lit[14];

  initial begin
    op_t  t;
    time  t0;
    n_cmp = 0; n_bad = 0; n_out = 0; held_v = 1'b0; held = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;

    vec[0]  = mk(0, 127, 24'h800000, 0, 0); lit[0]  = {3'b000, 32'h3F80_0000};
    vec[1]  = mk(0, 127, 24'h800000, 1, 0); lit[1]  = {3'b001, 32'h3F80_0000};
    vec[2]  = mk(0, 127, 24'hFFFFFF, 1, 0); lit[2]  = {3'b001, 32'h4000_0000};
    vec[3]  = mk(0, 254, 24'hFFFFFF, 1, 1); lit[3]  = {3'b101, 32'h7F80_0000};
    vec[4]  = mk(0, 0,   24'h7FFFFF, 1, 1); lit[4]  = {3'b001, 32'h0080_0000};
    vec[5]  = mk(0, 0,   24'h000001, 0, 1); lit[5]  = {3'b011, 32'h0000_0001};
    vec[6]  = mk(0, 127, 24'h800000, 0, 0); vec[6].nan = 1'b1; vec[6].inf = 1'b1;
                                            lit[6]  = {3'b000, 32'h7FC0_0000};
    vec[7]  = mk(0, 127, 24'h800001, 1, 0); lit[7]  = {3'b001, 32'h3F80_0002};
    vec[8]  = mk(1, 100, 24'hC00000, 1, 1); lit[8]  = {3'b001, 32'hB240_0001};
    vec[9]  = mk(1, 5,   24'h900000, 1, 1); vec[9].inf = 1'b1;
                                            lit[9]  = {3'b000, 32'hFF80_0000};
    vec[10] = mk(1, 0,   24'h000000, 0, 0); vec[10].zero = 1'b1;
                                            lit[10] = {3'b000, 32'h8000_0000};
    vec[11] = mk(1, 300, 24'h800000, 0, 0); lit[11] = {3'b101, 32'hFF80_0000};
    vec[12] = mk(0, 0,   24'h000000, 1, 0); lit[12] = {3'b011, 32'h0000_0000};
    vec[13] = mk(0, 253, 24'hFFFFFF, 1, 0); lit[13] = {3'b001, 32'h7F00_0000};

    for (int i = 0; i < 14; i++) chk($sformatf("model_pin%0d", i), model(vec[i]), lit[i]);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out", {bus_if.out_valid, got_now()}, 36'd0);
    chk("rst_in_ready", 35'(bus_if.in_ready), 35'd1);

    // Single-operand latency: accept at edge N, out_valid visible between N+1 and N+2.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(vec[0]);
    @(negedge clk);
    chk("lat_n1_valid", 35'(bus_if.out_valid), 35'd0);
    @(negedge clk);
    chk("lat_n2_valid", 35'(bus_if.out_valid), 35'd1);
    chk("lat_n2_result", got_now(), lit[0]);
    drain();

    // Back-to-back stream of every directed vector: one accept per cycle.
    t0 = $time;
    for (int i = 0; i < 14; i++) send(vec[i]);
    chk("throughput_time", 35'($time - t0), 35'(14 * 10));
    drain();

    // Stall: two operands fill the pipe, the third waits, then accept-in and accept-out coincide.
    n_out = 0;
    out_ready = 1'b0;
    send(vec[2]);
    send(vec[8]);
    drv = vec[13];
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready%0d", c), 35'(bus_if.in_ready), 35'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 35'(bus_if.in_ready), 35'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("stall_count", 35'(n_out), 35'd3);

    // Reset mid-stream with one result held in S2 and one operand in S1.
    out_ready = 1'b0;
    send(vec[1]);
    send(vec[7]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 35'(bus_if.out_valid), 35'd0);
    chk("async_rst_result", got_now(), 35'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    n_out = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", c), 35'(bus_if.out_valid), 35'd0);
    end
    chk("post_rst_no_out", 35'(n_out), 35'd0);
    @(posedge clk);
    #1;
    t = vec[5];
    send(t);
    drain();
    chk("post_rst_count", 35'(n_out), 35'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
